// File: rtl/rv_dmem_pkg.sv
// rv_dmem_pkg: shared types, constants and byte-merge helper for the data-memory arbiter.
package rv_dmem_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int RQ_CPU = 0;
    localparam int RQ_UART = 1;
    localparam logic [3:0] STRB_FULL = 4'hF;

    typedef enum logic [1:0] {IDLE = 2'd0, MERGE = 2'd1, WRITE = 2'd2} state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] wdata, input logic [31:0] old,
                                                input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        return m;
    endfunction
endpackage

// File: rtl/rv_rr_arbiter2.sv
// rv_rr_arbiter2: two-way round-robin grant; the loser of the last contention wins the next one.
module rv_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       accept,
    output logic [1:0] gnt
);
    logic last;

    always_comb gnt = !enable ? 2'b00 : (&req) ? (last ? 2'b01 : 2'b10) : req;

    always_ff @(posedge clk)
        if (rst) last <= 1'b1;
        else if (accept) last <= gnt[1];
endmodule

// File: rtl/rv_dmem_arbiter.sv
// rv_dmem_arbiter: shares one data-RAM port between the CPU LSU and the UART bridge.
// Define RV_DMEM_ARB_RMW_EN to turn partial-strobe stores into read-modify-write sequences.
module rv_dmem_arbiter
    import rv_dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_i,
    input  logic [1:0]        we_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic [3:0]        wstrb0_i,
    input  logic [3:0]        wstrb1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    logic              idle, win, accept, wr, rd;
    logic [ADDR_W-1:0] win_addr, addr_q;
    logic [DATA_W-1:0] win_wdata, wdata_q;

    rv_rr_arbiter2 u_rr (
        .clk(clk),
        .rst(rst),
        .req(req_i),
        .enable(idle && !rst),
        .accept(accept),
        .gnt(gnt_o)
    );

    assign win = gnt_o[RQ_UART];
    assign accept = |gnt_o;
    assign wr = accept && we_i[win];
    assign rd = accept && !we_i[win];
    assign win_addr = win ? addr1_i : addr0_i;
    assign win_wdata = win ? wdata1_i : wdata0_i;
    // addr_q/wdata_q hold the last driven values; they also carry the latched RMW target and word
    assign mem_addr_o = accept ? win_addr : addr_q;

`ifdef RV_DMEM_ARB_RMW_EN
    state_t     state;
    logic [3:0] strb_q, win_strb;
    logic       partial;

    assign win_strb = win ? wstrb1_i : wstrb0_i;
    assign idle = state == IDLE;
    assign partial = wr && win_strb != STRB_FULL && win_strb != 4'h0;
    assign mem_we_o = !rst && ((wr && win_strb == STRB_FULL) || state == WRITE);
    assign mem_wdata_o = wr ? win_wdata :
                         (state == MERGE) ? merge_bytes(wdata_q, mem_rdata_i, strb_q) : wdata_q;

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            strb_q <= 4'h0;
        end else begin
            state <= partial ? MERGE : (state == MERGE) ? WRITE : IDLE;
            if (partial) strb_q <= win_strb;
        end
`else
    assign idle = 1'b1;
    assign mem_we_o = wr;
    assign mem_wdata_o = wr ? win_wdata : wdata_q;
`endif

    always_ff @(posedge clk)
        if (rst) begin
            addr_q <= '0;
            wdata_q <= '0;
            rvalid_o <= 2'b00;
            rdata_o <= '0;
        end else begin
            addr_q <= mem_addr_o;
            wdata_q <= mem_wdata_o;
            rvalid_o <= rd ? gnt_o : 2'b00;
            if (rd) rdata_o <= mem_rdata_i;
        end
endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// tb_rv_dmem_arbiter: directed table, corner sequences and random traffic against a transaction-level model.
module tb_rv_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00, we = 2'b00;
    logic [9:0]  addr [2];
    logic [31:0] wd [2];
    logic [3:0]  st [2];
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    int          n_chk = 0, n_pass = 0;

`ifdef RV_DMEM_ARB_RMW_EN
    localparam logic NULL_WE = 1'b0;
`else
    localparam logic NULL_WE = 1'b1;
`endif

    rv_dmem_arbiter dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we),
        .addr0_i(addr[0]), .addr1_i(addr[1]), .wdata0_i(wd[0]), .wdata1_i(wd[1]),
        .wstrb0_i(st[0]), .wstrb1_i(st[1]), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level expectations: which strobes write whole words, which are dropped, which merge
    function automatic bit is_full(input logic [3:0] s);
`ifdef RV_DMEM_ARB_RMW_EN
        return s == 4'hF;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (d & mask) | (old & ~mask);
    endfunction

    int          m_last = 1, m_phase = 0;
    logic [1:0]  exp_rv = 2'b00, taken = 2'b00;
    logic [31:0] exp_rd = 0, p_data = 0;
    logic [9:0]  p_addr = 0;
    logic [3:0]  p_strb = 0;

    always @(negedge clk) begin
        int w;
        logic [1:0] eg;
        logic [31:0] mrg;
        taken = 2'b00;
        if (rst) begin
            chk("rst_gnt", gnt, 0);
            chk("rst_mem_we", mem_we, 0);
            m_last = 1;
            m_phase = 0;
            exp_rv = 2'b00;
        end else begin
            chk("rvalid", rvalid, exp_rv);
            if (exp_rv != 0) chk("rdata", rdata, exp_rd);
            exp_rv = 2'b00;
            if (m_phase == 2) begin
                mrg = merge(ref_mem[p_addr], p_data, p_strb);
                chk("write_gnt", gnt, 0);
                chk("write_we", mem_we, 1);
                chk("write_addr", mem_addr, p_addr);
                chk("write_data", mem_wdata, mrg);
                ref_mem[p_addr] = mrg;
                m_phase = 0;
            end else if (m_phase == 1) begin
                chk("merge_gnt", gnt, 0);
                chk("merge_we", mem_we, 0);
                chk("merge_addr", mem_addr, p_addr);
                m_phase = 2;
            end else begin
                w = (req == 2'b11) ? (m_last == 0 ? 1 : 0) : (req[1] ? 1 : 0);
                eg = (req == 2'b00) ? 2'b00 : 2'b01 << w;
                chk("gnt", gnt, eg);
                if (req == 2'b00) chk("idle_we", mem_we, 0);
                else begin
                    taken = eg;
                    m_last = w;
                    if (!we[w]) begin
                        chk("read_we", mem_we, 0);
                        chk("read_addr", mem_addr, addr[w]);
                        exp_rv = eg;
                        exp_rd = ref_mem[addr[w]];
                    end else if (is_full(st[w])) begin
                        chk("full_we", mem_we, 1);
                        chk("full_addr", mem_addr, addr[w]);
                        chk("full_data", mem_wdata, wd[w]);
                        ref_mem[addr[w]] = wd[w];
                    end else begin
                        chk("part_we", mem_we, 0);
                        if (st[w] != 4'h0) begin
                            p_addr = addr[w];
                            p_data = wd[w];
                            p_strb = st[w];
                            m_phase = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        req = req & ~taken;
    endtask

    task automatic issue(input int r, input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
        req[r] = 1'b1;
        we[r] = w;
        addr[r] = a;
        wd[r] = d;
        st[r] = s;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic drain();
        int k = 0;
        while ((req != 0 || m_phase != 0) && k < 50) begin
            step();
            k++;
        end
        if (k >= 50) begin
            n_chk++;
            $display("FAIL drain_timeout: req %b still pending after %0d cycles", req, k);
        end
    endtask

    typedef struct {
        logic [1:0]  req, we;
        logic [9:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  s0, s1;
        logic [1:0]  exp_gnt;
        logic        exp_we;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] w, input logic [9:0] a0, input logic [9:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1, input logic [3:0] s0,
                                input logic [3:0] s1, input logic [1:0] g, input logic e);
        vec_t v;
        v.req = r; v.we = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.s0 = s0; v.s1 = s1; v.exp_gnt = g; v.exp_we = e;
        return v;
    endfunction

    initial begin
        vec_t tbl [8];
        logic [1:0] seq [$];
        int left [2];
        int g0, g1, idle_cyc, alt_err;
        for (int i = 0; i < 1024; i++) preload(10'(i), 32'h5A5A_0000 ^ (i * 32'h0101_0101));
        for (int i = 0; i < 2; i++) begin
            addr[i] = 0; wd[i] = 0; st[i] = 0;
        end
        // last=1 after the opening contention, so r2/r3 go to requester 0 and r7 to requester 1
        tbl[0] = mk(2'b01, 2'b00, 3, 0, 0, 0, 4'hF, 4'hF, 2'b01, 1'b0);
        tbl[1] = mk(2'b10, 2'b10, 0, 12, 0, 32'h1234_5678, 4'hF, 4'hF, 2'b10, 1'b1);
        tbl[2] = mk(2'b11, 2'b00, 12, 13, 0, 0, 4'hF, 4'hF, 2'b01, 1'b0);
        tbl[3] = mk(2'b11, 2'b11, 14, 15, 32'hA1A2_A3A4, 32'hB1B2_B3B4, 4'hF, 4'hF, 2'b01, 1'b1);
        tbl[4] = mk(2'b01, 2'b01, 16, 0, 32'hC0C0_C0C0, 0, 4'h0, 4'hF, 2'b01, NULL_WE);
        tbl[5] = mk(2'b10, 2'b00, 0, 16, 0, 0, 4'hF, 4'hF, 2'b10, 1'b0);
        tbl[6] = mk(2'b01, 2'b01, 17, 0, 32'hD1D2_D3D4, 0, 4'b0011, 4'hF, 2'b01, NULL_WE);
        tbl[7] = mk(2'b11, 2'b10, 17, 17, 0, 32'hE1E2_E3E4, 4'hF, 4'hF, 2'b10, 1'b1);

        preload(5, 32'hCAFE_0005);
        issue(0, 0, 5, 0, 4'hF);
        issue(1, 0, 5, 0, 4'hF);
        step();
        step();
        chk("reset_gnt", gnt, 0);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        rst = 1'b0;
        @(negedge clk); chk("both5_gnt_a", gnt, 2'b01);
        step();
        @(negedge clk); chk("both5_gnt_b", gnt, 2'b10); chk("both5_rv_a", rvalid, 2'b01); chk("both5_rd_a", rdata, 32'hCAFE_0005);
        step();
        @(negedge clk); chk("both5_rv_b", rvalid, 2'b10); chk("both5_rd_b", rdata, 32'hCAFE_0005);
        step();

        for (int i = 0; i < 8; i++) begin
            req = tbl[i].req; we = tbl[i].we;
            addr[0] = tbl[i].a0; addr[1] = tbl[i].a1;
            wd[0] = tbl[i].d0; wd[1] = tbl[i].d1;
            st[0] = tbl[i].s0; st[1] = tbl[i].s1;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].exp_gnt);
            chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].exp_we);
            drain();
        end

        issue(0, 1, 10'h3FF, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk); chk("fw_gnt", gnt, 2'b01); chk("fw_we", mem_we, 1); chk("fw_addr", mem_addr, 10'h3FF);
        step();
        issue(1, 0, 10'h3FF, 0, 4'hF);
        @(negedge clk); chk("fw_rd_gnt", gnt, 2'b10);
        step();
        @(negedge clk); chk("fw_rv", rvalid, 2'b10); chk("fw_rdata", rdata, 32'hDEAD_BEEF);
        step();

        preload(7, 32'h1122_3344);
        issue(1, 1, 7, 32'hAABB_CCDD, 4'b0101);
`ifdef RV_DMEM_ARB_RMW_EN
        @(negedge clk); chk("pw_gnt", gnt, 2'b10); chk("pw_we0", mem_we, 0);
        step();
        issue(0, 0, 7, 0, 4'hF);
        @(negedge clk); chk("pw_gnt_merge", gnt, 2'b00); chk("pw_we1", mem_we, 0);
        step();
        @(negedge clk); chk("pw_gnt_write", gnt, 2'b00); chk("pw_we2", mem_we, 1); chk("pw_wdata", mem_wdata, 32'h11BB_33DD);
        step();
        @(negedge clk); chk("pw_gnt_next", gnt, 2'b01);
        step();
        @(negedge clk); chk("pw_rdata", rdata, 32'h11BB_33DD);
        step();
`else
        @(negedge clk); chk("pw_gnt", gnt, 2'b10); chk("pw_we", mem_we, 1); chk("pw_wdata", mem_wdata, 32'hAABB_CCDD);
        step();
        issue(0, 0, 7, 0, 4'hF);
        @(negedge clk); chk("pw_rd_gnt", gnt, 2'b01);
        step();
        @(negedge clk); chk("pw_rdata", rdata, 32'hAABB_CCDD);
        step();
`endif

        preload(9, 32'h5566_7788);
        issue(0, 1, 9, 32'hFFFF_FFFF, 4'h0);
        @(negedge clk); chk("null_gnt", gnt, 2'b01); chk("null_we", mem_we, NULL_WE);
        step();
        issue(1, 0, 9, 0, 4'hF);
        step();
        @(negedge clk); chk("null_rdata", rdata, NULL_WE ? 32'hFFFF_FFFF : 32'h5566_7788);
        step();

        left[0] = 8; left[1] = 8; g0 = 0; g1 = 0; idle_cyc = 0; alt_err = 0;
        issue(0, 0, 40, 0, 4'hF);
        issue(1, 0, 41, 0, 4'hF);
        for (int k = 0; k < 40 && left[0] + left[1] > 0; k++) begin
            @(negedge clk);
            seq.push_back(gnt);
            if (gnt == 2'b00) idle_cyc++;
            if (gnt[0]) begin g0++; left[0]--; end
            if (gnt[1]) begin g1++; left[1]--; end
            step();
            for (int r = 0; r < 2; r++) if (!req[r] && left[r] > 0) issue(r, 0, 10'(40 + r + 2 * left[r]), 0, 4'hF);
        end
        for (int i = 1; i < seq.size(); i++) if (seq[i] == seq[i-1]) alt_err++;
        chk("cont_g0", g0, 8);
        chk("cont_g1", g1, 8);
        chk("cont_idle", idle_cyc, 0);
        chk("cont_alt", alt_err, 0);
        chk("cont_cycles", seq.size(), 16);
        step();

`ifdef RV_DMEM_ARB_RMW_EN
        preload(20, 32'h0BAD_F00D);
        issue(0, 1, 20, 32'hFFFF_FFFF, 4'b0001);
        step();
        rst = 1'b1;
        @(negedge clk); chk("rstm_we", mem_we, 0);
        step();
        chk("rstm_rvalid", rvalid, 0);
        chk("rstm_rdata", rdata, 0);
        chk("rstm_addr", mem_addr, 0);
        chk("rstm_wdata", mem_wdata, 0);
        rst = 1'b0;
        issue(1, 0, 20, 0, 4'hF);
        step();
        @(negedge clk); chk("rstm_mem", rdata, 32'h0BAD_F00D);
        step();
`endif

        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++)
                if (!req[r] && $urandom_range(0, 2) != 0) begin
                    int sk = $urandom_range(0, 3);
                    issue(r, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                          sk == 0 ? 4'hF : sk == 1 ? 4'h0 : 4'($urandom_range(0, 15)));
                end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        req = 2'b00;
        step();
        drain();
        step();
        for (int a = 0; a < 16; a++) chk($sformatf("final_mem%0d", a), mem[a], ref_mem[a]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
